// File: rtl/level_det_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : level_det_pkg                                                 |
// | Purpose  : Shared types and constants for the hysteretic level detector. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package level_det_pkg;

  localparam int RISE_COUNT_W = 16;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    ARM_HIGH = 2'd1,
    HIGH     = 2'd2,
    ARM_LOW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLEAR = 2'd1,
    CNT_LOAD  = 2'd2,
    CNT_INC   = 2'd3
  } cnt_op_e;

endpackage

`default_nettype wire

// File: rtl/level_detector_hyst_if.sv
// +--------------------------------------------------------------------------+
// | Module   : level_detector_hyst_if                                        |
// | Purpose  : Sample/threshold bus and detector outputs; the stats ports    |
// |            exist only when LEVEL_DET_STATS_EN is defined.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface level_detector_hyst_if #(
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 8
);

  logic                      en;
  logic signed [WIDTH-1:0]   in;
  logic signed [WIDTH-1:0]   thresh_hi;
  logic signed [WIDTH-1:0]   thresh_lo;
  logic        [DWELL_W-1:0] dwell;
  logic                      level;
  logic                      rise;
  logic                      fall;
`ifdef LEVEL_DET_STATS_EN
  logic                                    clr_count;
  logic [level_det_pkg::RISE_COUNT_W-1:0]  rise_count;

  modport master (
    output en, in, thresh_hi, thresh_lo, dwell, clr_count,
    input  level, rise, fall, rise_count
  );

  modport slave (
    input  en, in, thresh_hi, thresh_lo, dwell, clr_count,
    output level, rise, fall, rise_count
  );
`else
  modport master (
    output en, in, thresh_hi, thresh_lo, dwell,
    input  level, rise, fall
  );

  modport slave (
    input  en, in, thresh_hi, thresh_lo, dwell,
    output level, rise, fall
  );
`endif

endinterface

`default_nettype wire

// File: rtl/level_det_dwell_cnt.sv
// +--------------------------------------------------------------------------+
// | Module   : level_det_dwell_cnt                                           |
// | Purpose  : Consecutive-sample run counter with dwell-complete compare.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module level_det_dwell_cnt
  import level_det_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire cnt_op_e            op,
  input  wire logic [DWELL_W-1:0] dwell,
  output logic                    done
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] w_dwell_eff;

  // Compare one bit wider so cnt+1 cannot wrap; >= lets a dwell lowered
  // mid-arm complete on the next qualifying sample.
  always_comb begin
    w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    done        = ({1'b0, cnt_q} + (DWELL_W + 1)'(1)) >= {1'b0, w_dwell_eff};
    cnt_d       = cnt_q;
    case (op)
      CNT_CLEAR: cnt_d = '0;
      CNT_LOAD:  cnt_d = DWELL_W'(1);
      CNT_INC:   cnt_d = cnt_q + DWELL_W'(1);
      default:   cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/level_detector_hyst.sv
// +--------------------------------------------------------------------------+
// | Module   : level_detector_hyst                                           |
// | Purpose  : Hysteretic, dwell-qualified level detector with rise/fall     |
// |            pulses; LEVEL_DET_STATS_EN adds a saturating rise counter.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module level_detector_hyst
  import level_det_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 8
) (
  input wire logic              clk,
  input wire logic              rst,
  level_detector_hyst_if.slave  bus
);

  state_e  state_q, state_d;
  logic    level_q, level_d;
  logic    rise_q,  rise_d;
  logic    fall_q,  fall_d;
  cnt_op_e w_cnt_op;
  logic    w_done;
  logic    w_q_hi;
  logic    w_q_lo;

  logic signed [WIDTH-1:0] w_in;
  logic signed [WIDTH-1:0] w_hi;
  logic signed [WIDTH-1:0] w_lo;

  assign w_in   = bus.in;
  assign w_hi   = bus.thresh_hi;
  assign w_lo   = bus.thresh_lo;
  assign w_q_hi = (w_in >= w_hi);
  assign w_q_lo = (w_in <= w_lo);

  level_det_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .op    (w_cnt_op),
    .dwell (bus.dwell),
    .done  (w_done)
  );

  // Low-side states look only at q_hi and high-side states only at q_lo, so
  // inverted thresholds oscillate rather than lock up.
  always_comb begin
    state_d  = state_q;
    w_cnt_op = CNT_HOLD;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (bus.en) begin
      case (state_q)
        LOW, ARM_HIGH: begin
          if (!w_q_hi) begin
            state_d  = LOW;
            w_cnt_op = CNT_CLEAR;
          end else if (w_done) begin
            state_d  = HIGH;
            w_cnt_op = CNT_CLEAR;
            rise_d   = 1'b1;
          end else begin
            state_d  = ARM_HIGH;
            w_cnt_op = (state_q == LOW) ? CNT_LOAD : CNT_INC;
          end
        end
        HIGH, ARM_LOW: begin
          if (!w_q_lo) begin
            state_d  = HIGH;
            w_cnt_op = CNT_CLEAR;
          end else if (w_done) begin
            state_d  = LOW;
            w_cnt_op = CNT_CLEAR;
            fall_d   = 1'b1;
          end else begin
            state_d  = ARM_LOW;
            w_cnt_op = (state_q == HIGH) ? CNT_LOAD : CNT_INC;
          end
        end
        default: begin
          state_d  = LOW;
          w_cnt_op = CNT_CLEAR;
        end
      endcase
    end
    level_d = (state_d == HIGH) || (state_d == ARM_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;

`ifdef LEVEL_DET_STATS_EN
  logic [RISE_COUNT_W-1:0] rise_count_q, rise_count_d;

  always_comb begin
    rise_count_d = rise_count_q;
    if (bus.clr_count) begin
      rise_count_d = '0;
    end else if (rise_d && (rise_count_q != {RISE_COUNT_W{1'b1}})) begin
      rise_count_d = rise_count_q + RISE_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_count_q <= '0;
    end else begin
      rise_count_q <= rise_count_d;
    end
  end

  assign bus.rise_count = rise_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_level_detector_hyst.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_level_detector_hyst                                        |
// | Purpose  : Directed-vector scoreboard bench for level_detector_hyst.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_level_detector_hyst;

  localparam int WIDTH   = 16;
  localparam int DWELL_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  level_detector_hyst_if #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) bus ();

  level_detector_hyst #(
    .WIDTH   (WIDTH),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        level;
    logic        rise;
    logic        fall;
    logic [15:0] rc;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          errors   = 0;
  int          vec_id   = 0;
  int          hi_v     = 1000;
  int          lo_v     = 200;
  int          dw_v     = 3;
  logic        clr_v    = 1'b0;
  logic [15:0] model_rc = 16'd0;

  // One driven cycle: apply inputs at negedge, queue what the next edge must produce.
  task automatic step(input logic r, input logic e, input int x,
                      input logic el, input logic er, input logic ef);
    exp_t ex;
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.in        = 16'(x);
    bus.thresh_hi = 16'(hi_v);
    bus.thresh_lo = 16'(lo_v);
    bus.dwell     = 8'(dw_v);
`ifdef LEVEL_DET_STATS_EN
    bus.clr_count = clr_v;
`endif
    if (r || clr_v) model_rc = 16'd0;
    else if (er && model_rc != 16'hFFFF) model_rc = model_rc + 16'd1;
    ex.level = el;
    ex.rise  = er;
    ex.fall  = ef;
    ex.rc    = model_rc;
    ex.id    = vec_id;
    vec_id++;
    sb.push_back(ex);
  endtask

  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      checks++;
      if ({bus.level, bus.rise, bus.fall} !== {ex.level, ex.rise, ex.fall}) begin
        errors++;
        $display("FAIL vec%0d level/rise/fall got %b%b%b want %b%b%b", ex.id,
                 bus.level, bus.rise, bus.fall, ex.level, ex.rise, ex.fall);
      end
`ifdef LEVEL_DET_STATS_EN
      checks++;
      if (bus.rise_count !== ex.rc) begin
        errors++;
        $display("FAIL vec%0d rise_count got %0d want %0d", ex.id, bus.rise_count, ex.rc);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en        = 1'b0;
    bus.in        = '0;
    bus.thresh_hi = 16'sd1000;
    bus.thresh_lo = 16'sd200;
    bus.dwell     = 8'd3;
`ifdef LEVEL_DET_STATS_EN
    bus.clr_count = 1'b0;
`endif
    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // three consecutive qualifying samples
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 1, 1, 0);
    step(0, 0, 1200, 1, 0, 0);
    // hysteresis band holds, then fall on third low sample
    for (int i = 0; i < 10; i++) step(0, 1, 500, 1, 0, 0);
    step(0, 1, 100, 1, 0, 0);
    step(0, 1, 100, 1, 0, 0);
    step(0, 1, 100, 0, 0, 1);
    step(0, 0, 100, 0, 0, 0);
    // a non-qualifying sample restarts the run
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1,  900, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 1, 1, 0);
    step(0, 1,  100, 1, 0, 0);
    step(0, 1,  100, 1, 0, 0);
    step(0, 1,  100, 0, 0, 1);
    // dwell lowered mid-arm completes on the next qualifying sample
    step(0, 1, 1200, 0, 0, 0);
    dw_v = 1;
    step(0, 1, 1200, 1, 1, 0);
    step(0, 1,  100, 0, 0, 1);
    // dwell=1 immediate, en low holds state
    step(0, 1, 1200, 1, 1, 0);
    step(0, 0,  100, 1, 0, 0);
    step(0, 0,  100, 1, 0, 0);
    step(0, 0,  100, 1, 0, 0);
    step(0, 1,  100, 0, 0, 1);
    dw_v = 0;
    step(0, 1, 1200, 1, 1, 0);
    step(0, 0, 1200, 1, 0, 0);
    step(0, 1,  100, 0, 0, 1);
    // thresholds are inclusive
    dw_v = 1;
    step(0, 1, 1000, 1, 1, 0);
    step(0, 1,  201, 1, 0, 0);
    step(0, 1,  200, 0, 0, 1);
    step(0, 1,  999, 0, 0, 0);
    // signed compare
    hi_v = -100; lo_v = -500;
    step(0, 1,    5, 1, 1, 0);
    step(0, 1,  100, 1, 0, 0);
    step(0, 1, -499, 1, 0, 0);
    step(0, 1, -500, 0, 0, 1);
    step(0, 1, -101, 0, 0, 0);
    // inverted thresholds oscillate
    hi_v = 100; lo_v = 500;
    step(0, 1, 300, 1, 1, 0);
    step(0, 1, 300, 0, 0, 1);
    step(0, 1, 300, 1, 1, 0);
    hi_v = 1000; lo_v = 200;
    step(0, 1, 100, 0, 0, 1);
    // reset mid-arm discards the run
    dw_v = 3;
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(1, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 0, 0, 0);
    step(0, 1, 1200, 1, 1, 0);
    // clear coincident with a rise wins
    dw_v = 1;
    step(0, 1, 100, 0, 0, 1);
    clr_v = 1'b1;
    step(0, 1, 1200, 1, 1, 0);
    clr_v = 1'b0;
    step(0, 1, 100, 0, 0, 1);
    step(0, 1, 1200, 1, 1, 0);
    step(0, 0, 1200, 1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
